decode_issue: RTL
=================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage directly upstream of the ALU: takes 32-bit words from fetch and splits them into ALU controls.
//  Evaluates Cond against the architectural flags, tracks pending writes in a register/flag scoreboard,
//  and holds one decoded instruction in an output register until the ALU accepts it (valid/ready).
// PARAMETERS
//  NREG     16  architectural registers; index width = $clog2(NREG)
//  STALL_W  16  width of saturating stall-cycle counter
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   fetch word valid
//  in_ready     out  1   stage accepts word this cycle
//  instr        in   32  [31:28]Cond [27:24]opcode [23]S [22:20]SR_Cont [19:16]Rd [15:12]Rn [11:8]Rm [7:3]SR_Bit; Imm=[15:0]
//  flags        in   4   architectural {N,Z,C,V}
//  out_valid    out  1   decoded instruction valid to ALU
//  out_ready    in   1   ALU accepts
//  opcode,Cond  out  4,4 registered fields
//  S            out  1   registered field
//  SR_Cont      out  3   registered field
//  SR_Bit       out  5   registered field
//  Imm          out  16  registered field
//  rd,rn,rm     out  4   registered register indices
//  wb_valid     in   1   register write retiring
//  wb_rd        in   4   retiring register index
//  wb_flag      in   1   flag write retiring
//  flush        in   1   drop held instruction, clear scoreboard
//  illegal      out  1   1-cycle pulse: undefined opcode consumed
//  issue_cnt    out  32  instructions issued (wraps)
//  stall_cnt    out  STALL_W  hazard-stall cycles (saturates at all-ones)
// BEHAVIOUR
//  Reset: out_valid=0, all registered fields=0, busy=0, flag_busy=0, illegal=0, counters=0.
//  Opcode classes: ALU 0000-0101 (reads Rn,Rm; writes Rd); MOVI 0110 (writes Rd); MOVR 0111 (reads Rm; writes Rd);
//   CMP 1011 (reads Rn,Rm; writes flags); LDR 1101 (reads Rn; writes Rd); STR 1110 (reads Rn,Rd); others undefined.
//  Any instruction with S=1 also writes flags.
//  busy_eff = busy & ~(wb_valid ? onehot(wb_rd) : 0); flag_eff = flag_busy & ~wb_flag. Retiring writes unblock the same cycle.
//  hazard = any read source busy_eff, or (Cond!=AL(1110) and flag_eff).
//  space = !out_valid | out_ready. in_ready = space & !hazard & !flush.
//  Accept (in_valid & in_ready), next cycle:
//   - defined opcode, cond_pass: output register loads all fields, out_valid=1, issue_cnt+1,
//     busy[Rd] set if writes Rd, flag_busy set if writes flags.
//   - defined opcode, cond fail: consumed, out_valid=0 (bubble), no scoreboard change.
//   - undefined opcode: consumed, out_valid=0, illegal=1 for one cycle.
//  No accept with out_ready & out_valid: out_valid->0. No accept and !out_ready: output register holds, fields stable.
//  Latency: 1 cycle from accept to out_valid; back-to-back issue at full rate when no hazards.
//  Same-cycle set and clear of one busy bit (issue writes r, wb_rd=r): set wins.
//  Cond uses flags sampled in the accept cycle; only legal because flag_eff=0 is required for Cond!=AL.
//  Cond codes: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V,
//   1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&N==V, 1101 LE Z|N!=V, 1110 AL 1, 1111 NV 0.
//  stall_cnt +1 each cycle with in_valid & space & hazard & !flush.
//  flush: next cycle out_valid=0, busy=0, flag_busy=0; no accept that cycle. Asserted only with no older instruction
//   in flight downstream. flush and rst both high: rst dominates, counters also clear.
// STRUCTURE
//  cpu_pkg: opcode constants, COND_* codes, instruction field bit positions, class predicates (writes_rd/reads_rn/...).
//  Sub-module cond_eval(Cond, flags -> pass): pure combinational, shared later by branch unit.
// TESTING
//  Reset then ADD r1,r2,r3 (0xE0012300), out_ready=1 -> out_valid 1 cycle later, opcode=0, rd=1, rn=2, rm=3, issue_cnt=1.
//  ADD r1 then SUB r4,r1,r5 -> in_ready=0, stall_cnt counts until wb_valid,wb_rd=1; SUB issues the cycle after wb.
//  flags=0100(Z), BEQ-style ADDEQ (Cond=0000) passes; Cond=0001 -> bubble, busy[Rd] unchanged.
//  CMP sets flag_busy; following Cond=0000 instr stalls until wb_flag; AL instr does not stall.
//  out_ready=0 for 5 cycles with held ALU op -> fields stable, in_ready=0; release -> next word issues.
//  Opcode 1000 -> illegal pulse, no out_valid; flush with busy[3] set -> busy cleared, out_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions: instruction field positions, opcode and condition
// encodings, and per-opcode register/flag usage predicates.
package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 24;
    localparam int S_BIT    = 23;
    localparam int SRC_LSB  = 20;
    localparam int RD_LSB   = 16;
    localparam int RN_LSB   = 12;
    localparam int RM_LSB   = 8;
    localparam int SRB_LSB  = 3;

    localparam logic [3:0] OP_ALU_LAST = 4'h5;
    localparam logic [3:0] OP_MOVI     = 4'h6;
    localparam logic [3:0] OP_MOVR     = 4'h7;
    localparam logic [3:0] OP_CMP      = 4'hB;
    localparam logic [3:0] OP_LDR      = 4'hD;
    localparam logic [3:0] OP_STR      = 4'hE;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_ALU_LAST;
    endfunction

    function automatic logic is_defined(input logic [3:0] op);
        return is_alu(op) || op == OP_MOVI || op == OP_MOVR || op == OP_CMP ||
               op == OP_LDR || op == OP_STR;
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return is_alu(op) || op == OP_MOVI || op == OP_MOVR || op == OP_LDR;
    endfunction

    function automatic logic writes_flags(input logic [3:0] op, input logic s);
        return op == OP_CMP || s;
    endfunction

    function automatic logic reads_rn(input logic [3:0] op);
        return is_alu(op) || op == OP_CMP || op == OP_LDR || op == OP_STR;
    endfunction

    function automatic logic reads_rm(input logic [3:0] op);
        return is_alu(op) || op == OP_MOVR || op == OP_CMP;
    endfunction

    function automatic logic reads_rd(input logic [3:0] op);
        return op == OP_STR;
    endfunction

endpackage

// File: rtl/decode_issue_cond_eval.sv
// Condition-code evaluator: decides whether an instruction with the given Cond
// executes under architectural flags {N,Z,C,V}. Purely combinational.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits fetch words into ALU controls, blocks on register
// and flag scoreboard hazards, and holds one decoded op until the ALU accepts it.
module decode_issue
    import cpu_pkg::*;
#(
    parameter int NREG    = 16,
    parameter int STALL_W = 16,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [3:0]         flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         opcode,
    output logic [3:0]         Cond,
    output logic               S,
    output logic [2:0]         SR_Cont,
    output logic [4:0]         SR_Bit,
    output logic [15:0]        Imm,
    output logic [IDX_W-1:0]   rd,
    output logic [IDX_W-1:0]   rn,
    output logic [IDX_W-1:0]   rm,
    input  logic               wb_valid,
    input  logic [IDX_W-1:0]   wb_rd,
    input  logic               wb_flag,
    input  logic               flush,
    output logic               illegal,
    output logic [31:0]        issue_cnt,
    output logic [STALL_W-1:0] stall_cnt
);
    logic [3:0]       f_cond, f_op;
    logic [IDX_W-1:0] f_rd, f_rn, f_rm;
    logic             cond_pass;

    assign f_cond = instr[COND_LSB +: 4];
    assign f_op   = instr[OP_LSB +: 4];
    assign f_rd   = IDX_W'(instr[RD_LSB +: 4]);
    assign f_rn   = IDX_W'(instr[RN_LSB +: 4]);
    assign f_rm   = IDX_W'(instr[RM_LSB +: 4]);

    cond_eval u_cond (.cond(f_cond), .flags(flags), .pass(cond_pass));

    logic [NREG-1:0] busy_q, busy_d, busy_eff, wb_mask, set_mask;
    logic            flag_busy_q, flag_busy_d, flag_eff;
    logic            out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [31:0]     instr_q, instr_d, issue_q, issue_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic            hazard, space, accept, issue;

    // Retiring writes release their scoreboard bits in the same cycle.
    assign wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
    assign busy_eff = busy_q & ~wb_mask;
    assign flag_eff = flag_busy_q & ~wb_flag;

    assign hazard = (reads_rn(f_op) && busy_eff[f_rn]) ||
                    (reads_rm(f_op) && busy_eff[f_rm]) ||
                    (reads_rd(f_op) && busy_eff[f_rd]) ||
                    (f_cond != COND_AL && flag_eff);
    assign space    = !out_valid_q || out_ready;
    assign in_ready = space && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && is_defined(f_op) && cond_pass;
    assign set_mask = (issue && writes_rd(f_op)) ? (NREG'(1) << f_rd) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        issue_d     = issue_q;
        stall_d     = stall_q;
        illegal_d   = 1'b0;
        busy_d      = busy_eff | set_mask;
        flag_busy_d = flag_eff || (issue && writes_flags(f_op, instr[S_BIT]));
        if (flush) begin
            out_valid_d = 1'b0;
            busy_d      = '0;
            flag_busy_d = 1'b0;
        end else begin
            if (issue) begin
                out_valid_d = 1'b1;
                instr_d     = instr;
                issue_d     = issue_q + 32'd1;
            end else if (accept || out_ready) begin
                out_valid_d = 1'b0;
            end
            illegal_d = accept && !is_defined(f_op);
            if (in_valid && space && hazard && !(&stall_q))
                stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            busy_q      <= '0;
            flag_busy_q <= 1'b0;
            illegal_q   <= 1'b0;
            issue_q     <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            busy_q      <= busy_d;
            flag_busy_q <= flag_busy_d;
            illegal_q   <= illegal_d;
            issue_q     <= issue_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Cond      = instr_q[COND_LSB +: 4];
    assign opcode    = instr_q[OP_LSB +: 4];
    assign S         = instr_q[S_BIT];
    assign SR_Cont   = instr_q[SRC_LSB +: 3];
    assign SR_Bit    = instr_q[SRB_LSB +: 5];
    assign Imm       = instr_q[15:0];
    assign rd        = IDX_W'(instr_q[RD_LSB +: 4]);
    assign rn        = IDX_W'(instr_q[RN_LSB +: 4]);
    assign rm        = IDX_W'(instr_q[RM_LSB +: 4]);
    assign illegal   = illegal_q;
    assign issue_cnt = issue_q;
    assign stall_cnt = stall_q;
endmodule
